// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port integer register file.
// Write-port arbitration lives here so the array and the read ports resolve conflicts identically.
package rf_pkg;

    localparam int unsigned DefDataW   = 64;
    localparam int unsigned DefNumRegs = 32;
    localparam int unsigned MaxWr      = 8;
    localparam int unsigned MaxAddrW   = 16;
    localparam int unsigned WrIdxW     = $clog2(MaxWr);

    typedef struct packed {
        logic              hit;
        logic [WrIdxW-1:0] idx;
    } wr_win_t;

    // Highest-index enabled write port targeting addr wins.
    function automatic wr_win_t rf_win_port(
        input logic [MaxWr-1:0]               we,
        input logic [MaxWr-1:0][MaxAddrW-1:0] waddr,
        input int unsigned                    num_wr,
        input logic [MaxAddrW-1:0]            addr
    );
        wr_win_t win;
        win = '0;
        for (int unsigned i = 0; i < MaxWr; i++) begin
            if (i < num_wr && we[i] && waddr[i] == addr) begin
                win.hit = 1'b1;
                win.idx = WrIdxW'(i);
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One synchronous read port: address latch, write-first bypass / locked refresh,
// zero and out-of-range masking, and the output register.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned NUM_REGS = DefNumRegs,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              lock_i,
    input  logic [ADDR_W-1:0]                 raddr_i,
    input  logic [DATA_W-1:0]                 arr_data_i,
    input  logic [MaxWr-1:0]                  we_i,
    input  logic [MaxWr-1:0][MaxAddrW-1:0]    waddr_i,
    input  logic [DATA_W-1:0]                 wdata_i [MaxWr],
    output logic [DATA_W-1:0]                 rdata_o
);

    localparam logic [ADDR_W:0] NumRegsW = (ADDR_W + 1)'(NUM_REGS);

    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              sel_valid;
    wr_win_t           win;

    // While locked, the latched address is the one watched for refreshing writes.
    always_comb begin
        sel_addr   = lock_i ? lat_addr_q : raddr_i;
        sel_valid  = ({1'b0, sel_addr} < NumRegsW) && !((ZERO_REG != 0) && (sel_addr == '0));
        win        = rf_win_port(we_i, waddr_i, NUM_WR, MaxAddrW'(sel_addr));
        lat_addr_d = lat_addr_q;
        rdata_d    = rdata_q;
        if (!lock_i) begin
            lat_addr_d = raddr_i;
            if (!sel_valid) begin
                rdata_d = '0;
            end else if (win.hit) begin
                rdata_d = wdata_i[win.idx];
            end else begin
                rdata_d = arr_data_i;
            end
        end else if (sel_valid && win.hit) begin
            rdata_d = wdata_i[win.idx];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lat_addr_q <= '0;
            rdata_q    <= '0;
        end else begin
            lat_addr_q <= lat_addr_d;
            rdata_q    <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/int_regfile_mp.sv
// Multi-port integer register file: flop array with highest-index write arbitration,
// NUM_RD one-cycle-latency read ports with bypass and lock/refresh.
module int_regfile_mp
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned NUM_REGS = DefNumRegs,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       lock,
    input  logic [NUM_WR-1:0]          we,
    input  logic [NUM_WR*ADDR_W-1:0]   waddr,
    input  logic [NUM_WR*DATA_W-1:0]   wdata,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata
);

    localparam logic [ADDR_W:0] NumRegsW = (ADDR_W + 1)'(NUM_REGS);

    logic [MaxWr-1:0]               we_ext;
    logic [MaxWr-1:0][MaxAddrW-1:0] waddr_ext;
    logic [DATA_W-1:0]              wdata_ext [MaxWr];

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              reg_we [NUM_REGS];
    logic [DATA_W-1:0] reg_wd [NUM_REGS];
    wr_win_t           reg_win [NUM_REGS];

    // Widen write ports to the package's fixed maximum so arbitration is shared.
    always_comb begin
        we_ext    = '0;
        waddr_ext = '0;
        for (int unsigned i = 0; i < MaxWr; i++) begin
            wdata_ext[i] = '0;
        end
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            we_ext[i]    = we[i];
            waddr_ext[i] = MaxAddrW'(waddr[i*ADDR_W +: ADDR_W]);
            wdata_ext[i] = wdata[i*DATA_W +: DATA_W];
        end
    end

    // Out-of-range write addresses match no register and are dropped.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            reg_win[r] = rf_win_port(we_ext, waddr_ext, NUM_WR, MaxAddrW'(r));
            reg_we[r]  = reg_win[r].hit && !((ZERO_REG != 0) && (r == 0));
            reg_wd[r]  = wdata_ext[reg_win[r].idx];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (reg_we[r]) begin
                    regs_q[r] <= reg_wd[r];
                end
            end
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] arr;

        assign ra = raddr[j*ADDR_W +: ADDR_W];

        always_comb begin
            arr = '0;
            if ({1'b0, ra} < NumRegsW) begin
                arr = regs_q[ra];
            end
        end

        rf_read_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ADDR_W   (ADDR_W),
            .NUM_WR   (NUM_WR),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .clk_i      (CLK),
            .rst_i      (RST),
            .lock_i     (lock),
            .raddr_i    (ra),
            .arr_data_i (arr),
            .we_i       (we_ext),
            .waddr_i    (waddr_ext),
            .wdata_i    (wdata_ext),
            .rdata_o    (rdata[j*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_int_regfile_mp.sv
// Self-checking bench for int_regfile_mp: default instance plus a 24-reg/3-read/32-bit instance,
// directed vector table, hand sequences and random traffic against a behavioural model.
module tb_int_regfile_mp;

    typedef struct {
        logic             lock;
        logic [1:0]       we;
        logic [1:0][4:0]  wa;
        logic [1:0][63:0] wd;
        logic [2:0][4:0]  ra;
    } stim_t;

    typedef struct {
        string       name;
        int          inst;
        int          port;
        logic [63:0] exp;
    } exp_t;

    typedef struct {
        stim_t       s;
        logic [63:0] e0;
        logic [63:0] e1;
    } vec_t;

    logic         CLK = 1'b0;
    logic         RST;
    logic         lock_a, lock_b;
    logic [1:0]   we_a, we_b;
    logic [9:0]   waddr_a, waddr_b;
    logic [127:0] wdata_a;
    logic [63:0]  wdata_b;
    logic [9:0]   raddr_a;
    logic [14:0]  raddr_b;
    logic [127:0] rdata_a;
    logic [95:0]  rdata_b;

    always #5 CLK = ~CLK;

    int_regfile_mp dut_a (
        .CLK   (CLK),
        .RST   (RST),
        .lock  (lock_a),
        .we    (we_a),
        .waddr (waddr_a),
        .wdata (wdata_a),
        .raddr (raddr_a),
        .rdata (rdata_a)
    );

    int_regfile_mp #(
        .DATA_W   (32),
        .NUM_REGS (24),
        .NUM_RD   (3)
    ) dut_b (
        .CLK   (CLK),
        .RST   (RST),
        .lock  (lock_b),
        .we    (we_b),
        .waddr (waddr_b),
        .wdata (wdata_b),
        .raddr (raddr_b),
        .rdata (rdata_b)
    );

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sbq[$];

    logic [63:0] mregs [2][32];
    logic [63:0] mrd   [2][3];
    logic [4:0]  mlat  [2][3];

    function automatic stim_t mk(input logic lck, input logic [1:0] w, input logic [4:0] wa0,
                                 input logic [4:0] wa1, input logic [63:0] wd0,
                                 input logic [63:0] wd1, input logic [4:0] ra0,
                                 input logic [4:0] ra1, input logic [4:0] ra2);
        stim_t s;
        s.lock  = lck;
        s.we    = w;
        s.wa[0] = wa0;
        s.wa[1] = wa1;
        s.wd[0] = wd0;
        s.wd[1] = wd1;
        s.ra[0] = ra0;
        s.ra[1] = ra1;
        s.ra[2] = ra2;
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(1'b0, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0);
    endfunction

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    function automatic logic [63:0] actual(input int inst, input int port);
        if (inst == 0) return rdata_a[port*64 +: 64];
        return {32'h0, rdata_b[port*32 +: 32]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) mregs[k][r] = '0;
            for (int p = 0; p < 3; p++) begin
                mrd[k][p]  = '0;
                mlat[k][p] = '0;
            end
        end
    endtask

    // Reads see the pre-edge array plus same-cycle writes; writes apply in port order.
    task automatic model_step(input int k, input stim_t s);
        int          nr;
        int          np;
        logic [63:0] dm;
        logic [4:0]  a;
        logic [63:0] v;
        nr = (k == 0) ? 32 : 24;
        np = (k == 0) ? 2 : 3;
        dm = (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        for (int p = 0; p < np; p++) begin
            if (!s.lock) begin
                a          = s.ra[p];
                mlat[k][p] = a;
                v          = '0;
                if (a != 0 && int'(a) < nr) begin
                    v = mregs[k][a];
                    for (int w = 0; w < 2; w++) if (s.we[w] && s.wa[w] == a) v = s.wd[w] & dm;
                end
                mrd[k][p] = v;
            end else begin
                a = mlat[k][p];
                if (a != 0 && int'(a) < nr) begin
                    for (int w = 0; w < 2; w++) if (s.we[w] && s.wa[w] == a) mrd[k][p] = s.wd[w] & dm;
                end
            end
        end
        for (int w = 0; w < 2; w++) begin
            if (s.we[w] && s.wa[w] != 0 && int'(s.wa[w]) < nr) mregs[k][s.wa[w]] = s.wd[w] & dm;
        end
    endtask

    task automatic drive(input stim_t sa, input stim_t sb);
        lock_a  = sa.lock;
        we_a    = sa.we;
        waddr_a = sa.wa;
        wdata_a = sa.wd;
        raddr_a = sa.ra[1:0];
        lock_b  = sb.lock;
        we_b    = sb.we;
        waddr_b = sb.wa;
        wdata_b = {sb.wd[1][31:0], sb.wd[0][31:0]};
        raddr_b = sb.ra;
    endtask

    task automatic push(input string name, input int inst, input int port, input logic [63:0] e);
        exp_t x;
        x.name = name;
        x.inst = inst;
        x.port = port;
        x.exp  = e;
        sbq.push_back(x);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] e);
        n_vec++;
        if (act !== e) begin
            n_err++;
            $display("FAIL %s: rdata=%h expected=%h", name, act, e);
        end
    endtask

    task automatic cycle_go(input stim_t sa, input stim_t sb, input bit chk_a, input bit chk_b);
        exp_t x;
        drive(sa, sb);
        model_step(0, sa);
        model_step(1, sb);
        if (chk_a) for (int p = 0; p < 2; p++) push($sformatf("model_a_p%0d", p), 0, p, mrd[0][p]);
        if (chk_b) for (int p = 0; p < 3; p++) push($sformatf("model_b_p%0d", p), 1, p, mrd[1][p]);
        @(posedge CLK);
        #1;
        while (sbq.size() > 0) begin
            x = sbq.pop_front();
            check(x.name, actual(x.inst, x.port), x.exp);
        end
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;
        tbl.push_back('{mk(0, 2'b01, 0, 0, 64'hDEAD, 0, 0, 0, 0), 64'h0, 64'h0});
        tbl.push_back('{mk(0, 2'b00, 0, 0, 0, 0, 1, 2, 0), 64'h0, 64'h0});
        tbl.push_back('{mk(0, 2'b01, 5, 0, 64'h1234, 0, 5, 0, 0), 64'h1234, 64'h0});
        tbl.push_back('{mk(0, 2'b00, 0, 0, 0, 0, 0, 5, 0), 64'h0, 64'h1234});
        tbl.push_back('{mk(0, 2'b11, 7, 7, 64'hAAAA, 64'hBBBB, 7, 0, 0), 64'hBBBB, 64'h0});
        tbl.push_back('{mk(0, 2'b00, 0, 0, 0, 0, 7, 7, 0), 64'hBBBB, 64'hBBBB});
        tbl.push_back('{mk(0, 2'b01, 3, 0, 64'h11, 0, 0, 0, 0), 64'h0, 64'h0});
        tbl.push_back('{mk(0, 2'b00, 0, 0, 0, 0, 3, 5, 0), 64'h11, 64'h1234});
        tbl.push_back('{mk(1, 2'b01, 9, 0, 64'h99, 0, 9, 7, 0), 64'h11, 64'h1234});
        tbl.push_back('{mk(1, 2'b01, 4, 0, 64'h44, 0, 9, 7, 0), 64'h11, 64'h1234});
        tbl.push_back('{mk(1, 2'b10, 0, 3, 0, 64'h22, 9, 7, 0), 64'h22, 64'h1234});
        tbl.push_back('{mk(1, 2'b00, 0, 0, 0, 0, 9, 7, 0), 64'h22, 64'h1234});
        tbl.push_back('{mk(0, 2'b00, 0, 0, 0, 0, 9, 4, 0), 64'h99, 64'h44});
        tbl.push_back('{mk(0, 2'b11, 12, 13, 64'hC0, 64'hD1, 12, 13, 0), 64'hC0, 64'hD1});
        tbl.push_back('{mk(1, 2'b11, 12, 12, 64'hE0, 64'hE1, 0, 0, 0), 64'hE1, 64'hD1});
        tbl.push_back('{mk(0, 2'b00, 0, 0, 0, 0, 12, 13, 0), 64'hE1, 64'hD1});

        RST = 1'b1;
        drive(idle(), idle());
        model_reset();
        #2;
        for (int p = 0; p < 2; p++) check($sformatf("reset_a_p%0d", p), actual(0, p), 64'h0);
        for (int p = 0; p < 3; p++) check($sformatf("reset_b_p%0d", p), actual(1, p), 64'h0);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            push($sformatf("vec%0d_p0", i), 0, 0, v.e0);
            push($sformatf("vec%0d_p1", i), 0, 1, v.e1);
            cycle_go(v.s, idle(), 1'b0, 1'b1);
        end

        // Reset mid-operation with a write pending; the write must be lost.
        drive(mk(0, 2'b01, 5, 0, 64'hFF, 0, 5, 5, 0), mk(0, 2'b01, 5, 0, 64'hFF, 0, 5, 5, 5));
        #3;
        RST = 1'b1;
        #1;
        for (int p = 0; p < 2; p++) check($sformatf("midrst_a_p%0d", p), actual(0, p), 64'h0);
        for (int p = 0; p < 3; p++) check($sformatf("midrst_b_p%0d", p), actual(1, p), 64'h0);
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 32; i++) begin
            for (int p = 0; p < 2; p++) push($sformatf("clr_r%0d_a_p%0d", i, p), 0, p, 64'h0);
            for (int p = 0; p < 3; p++) push($sformatf("clr_r%0d_b_p%0d", i, p), 1, p, 64'h0);
            cycle_go(mk(0, 2'b00, 0, 0, 0, 0, 5'(i), 5'(i), 0),
                     mk(0, 2'b00, 0, 0, 0, 0, 5'(i), 5'(i), 5'(31 - i)), 1'b0, 1'b0);
        end

        push("zero_bypass_p0", 0, 0, 64'h0);
        push("zero_bypass_p1", 0, 1, 64'h0);
        cycle_go(mk(0, 2'b10, 0, 0, 0, 64'hDEAD, 0, 0, 0), idle(), 1'b0, 1'b1);
        push("zero_array_p0", 0, 0, 64'h0);
        push("zero_array_p1", 0, 1, 64'h0);
        cycle_go(idle(), idle(), 1'b0, 1'b1);

        // Narrow instance: addresses 24..31 are out of range.
        push("oor_wr_b_p0", 1, 0, 64'h0);
        push("oor_wr_b_p1", 1, 1, 64'h0);
        push("oor_wr_b_p2", 1, 2, 64'h0);
        cycle_go(idle(), mk(0, 2'b01, 30, 0, 64'hCAFE, 0, 30, 23, 0), 1'b1, 1'b0);
        push("top_reg_b_p0", 1, 0, 64'h0);
        push("top_reg_b_p1", 1, 1, 64'h3333_4444);
        push("top_reg_b_p2", 1, 2, 64'h3333_4444);
        cycle_go(idle(), mk(0, 2'b11, 23, 30, 64'h1111_2222_3333_4444, 64'h5555, 30, 23, 23),
                 1'b1, 1'b0);
        push("oor_rd_b_p0", 1, 0, 64'h0);
        push("oor_rd_b_p1", 1, 1, 64'h3333_4444);
        push("oor_rd_b_p2", 1, 2, 64'h0);
        cycle_go(idle(), mk(0, 2'b00, 0, 0, 0, 0, 30, 23, 22), 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            stim_t sa;
            stim_t sb;
            sa = mk(($urandom_range(0, 3) == 0), 2'($urandom), rnd_addr(), rnd_addr(),
                    {$urandom, $urandom}, {$urandom, $urandom}, rnd_addr(), rnd_addr(), 0);
            sb = mk(($urandom_range(0, 3) == 0), 2'($urandom), rnd_addr(), rnd_addr(),
                    {$urandom, $urandom}, {$urandom, $urandom}, rnd_addr(), rnd_addr(),
                    rnd_addr());
            cycle_go(sa, sb, 1'b1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
